// File: rtl/rv_g_wb_arbiter.sv
// rv_g_wb_arbiter: round-robin arbiter that merges NUM_REQ register writeback
// requesters into a single register-file write port (unified 6-bit address,
// bit 5 selects the FP file). Writes to x0 are accepted but not enabled.
//
// Optional output register stage: define RV_G_WB_ARBITER_OUT_REG_EN to
// register wr_en_o/wr_addr_o/wr_data_o/gnt_idx_o (one cycle of latency).
// Without the macro those outputs are combinational from the current grant.
module rv_g_wb_arbiter #(
  parameter int XLEN    = 64,
  parameter int FLEN    = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  input  logic [NUM_REQ-1:0][5:0]                       req_addr_i,
  input  logic [NUM_REQ-1:0][((XLEN > FLEN) ? XLEN : FLEN)-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  output logic                                          wr_en_o,
  output logic [5:0]                                    wr_addr_o,
  output logic [((XLEN > FLEN) ? XLEN : FLEN)-1:0]      wr_data_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_idx_o
);

  localparam int MaxLen = (XLEN > FLEN) ? XLEN : FLEN;
  localparam int IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic              gnt_found;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   cand;
  int unsigned       cand_sum;

  logic              wr_en_d;
  logic [5:0]        wr_addr_d;
  logic [MaxLen-1:0] wr_data_d;
  logic [IdxW-1:0]   gnt_idx_d;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ; reset blocks any grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    cand_sum  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = int'(ptr_q) + k;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      cand = IdxW'(cand_sum);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (!rst_ni) begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
    end
  end

  // One-hot ready toward the granted requester; a grant is always a transfer.
  always_comb begin
    req_ready_o = '0;
    if (gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  // Pointer moves one past the winner; holds when nothing transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) begin
      if (gnt_idx == IdxW'(NUM_REQ - 1)) ptr_d = '0;
      else                               ptr_d = gnt_idx + IdxW'(1);
    end
  end

  // Write port contents for this cycle's transfer; x0 is carried but never enabled.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    gnt_idx_d = '0;
    if (gnt_found) begin
      wr_en_d   = (req_addr_i[gnt_idx] != 6'd0);
      wr_addr_d = req_addr_i[gnt_idx];
      wr_data_d = req_data_i[gnt_idx];
      gnt_idx_d = gnt_idx;
    end
  end

`ifdef RV_G_WB_ARBITER_OUT_REG_EN
  logic              wr_en_q;
  logic [5:0]        wr_addr_q;
  logic [MaxLen-1:0] wr_data_q;
  logic [IdxW-1:0]   gnt_idx_q;

  // Pointer and output stage; reset drops any write still sitting in the stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      gnt_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign gnt_idx_o = gnt_idx_q;
`else
  // Pointer state only; the write port is driven straight from the grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign wr_en_o   = wr_en_d;
  assign wr_addr_o = wr_addr_d;
  assign wr_data_o = wr_data_d;
  assign gnt_idx_o = gnt_idx_d;
`endif

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Directed bench for rv_g_wb_arbiter (NUM_REQ=4, MaxLen=64). Follows the
// RV_G_WB_ARBITER_OUT_REG_EN macro to pick when write-port outputs are checked.
module tb_rv_g_wb_arbiter;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][5:0] req_addr;
  logic [3:0][63:0] req_data;
  logic [3:0]      req_ready;
  logic            wr_en;
  logic [5:0]      wr_addr;
  logic [63:0]     wr_data;
  logic [1:0]      gnt_idx;

  int n_vec = 0;
  int n_err = 0;

  rv_g_wb_arbiter #(.XLEN(64), .FLEN(32), .NUM_REQ(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .gnt_idx_o   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic e_en, input logic [5:0] e_addr,
                        input logic [63:0] e_data, input logic [1:0] e_idx);
    chk(tag, "wr_en",   {63'd0, wr_en},   {63'd0, e_en});
    chk(tag, "wr_addr", {58'd0, wr_addr}, {58'd0, e_addr});
    chk(tag, "wr_data", wr_data,          e_data);
    chk(tag, "gnt_idx", {62'd0, gnt_idx}, {62'd0, e_idx});
  endtask

  // One clock cycle: drive, check ready, check write port at the build's latency.
  task automatic step(input string tag, input logic rst, input logic [3:0] v,
                      input logic [3:0] e_rdy, input logic e_en, input logic [5:0] e_addr,
                      input logic [63:0] e_data, input logic [1:0] e_idx);
    rst_n     = rst;
    req_valid = v;
    #1;
    chk(tag, "ready", {60'd0, req_ready}, {60'd0, e_rdy});
`ifndef RV_G_WB_ARBITER_OUT_REG_EN
    chk_wr(tag, e_en, e_addr, e_data, e_idx);
`endif
    @(posedge clk);
    #1;
`ifdef RV_G_WB_ARBITER_OUT_REG_EN
    chk_wr(tag, e_en, e_addr, e_data, e_idx);
`endif
  endtask

  localparam logic [63:0] DB = 64'hA0A0_0000_0000_0000;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 6'(i + 1);
      req_data[i] = DB + 64'(i);
    end

    // Reset with every requester valid: nothing granted, nothing written.
    step("rst0", 1'b0, 4'hF, 4'h0, 1'b0, 6'd0, 64'd0, 2'd0);
    step("rst1", 1'b0, 4'hF, 4'h0, 1'b0, 6'd0, 64'd0, 2'd0);

    // All valid: strict rotation 0,1,2,3,0,1,2,3 from ptr 0.
    step("rr0", 1'b1, 4'hF, 4'b0001, 1'b1, 6'd1, DB + 64'd0, 2'd0);
    step("rr1", 1'b1, 4'hF, 4'b0010, 1'b1, 6'd2, DB + 64'd1, 2'd1);
    step("rr2", 1'b1, 4'hF, 4'b0100, 1'b1, 6'd3, DB + 64'd2, 2'd2);
    step("rr3", 1'b1, 4'hF, 4'b1000, 1'b1, 6'd4, DB + 64'd3, 2'd3);
    step("rr4", 1'b1, 4'hF, 4'b0001, 1'b1, 6'd1, DB + 64'd0, 2'd0);
    step("rr5", 1'b1, 4'hF, 4'b0010, 1'b1, 6'd2, DB + 64'd1, 2'd1);
    step("rr6", 1'b1, 4'hF, 4'b0100, 1'b1, 6'd3, DB + 64'd2, 2'd2);
    step("rr7", 1'b1, 4'hF, 4'b1000, 1'b1, 6'd4, DB + 64'd3, 2'd3);

    // Only 2 and 3 valid from ptr 0: grants 2,3,2 (ptr 3,0,3).
    step("p23a", 1'b1, 4'b1100, 4'b0100, 1'b1, 6'd3, DB + 64'd2, 2'd2);
    step("p23b", 1'b1, 4'b1100, 4'b1000, 1'b1, 6'd4, DB + 64'd3, 2'd3);
    step("p23c", 1'b1, 4'b1100, 4'b0100, 1'b1, 6'd3, DB + 64'd2, 2'd2);

    // Idle: no write, port zeroed, ptr holds at 3.
    step("idle", 1'b1, 4'h0, 4'h0, 1'b0, 6'd0, 64'd0, 2'd0);

    // x0 write from requester 1 transfers but is not enabled (ptr 3 -> 2).
    req_addr[1] = 6'd0;
    req_data[1] = 64'hDEAD;
    step("x0", 1'b1, 4'b0010, 4'b0010, 1'b0, 6'd0, 64'hDEAD, 2'd1);
    req_addr[1] = 6'd33;
    req_data[1] = 64'hBEEF;
    step("f1", 1'b1, 4'b0010, 4'b0010, 1'b1, 6'd33, 64'hBEEF, 2'd1);

    // ptr 2 with 0 and 3 valid: 3 wins, then f0 from requester 0 is enabled.
    req_addr[0] = 6'd32;
    req_data[0] = 64'hF0F0_F0F0_F0F0_F0F0;
    req_addr[3] = 6'd5;
    req_data[3] = 64'h3333;
    step("w3", 1'b1, 4'b1001, 4'b1000, 1'b1, 6'd5, 64'h3333, 2'd3);
    step("f0", 1'b1, 4'b0001, 4'b0001, 1'b1, 6'd32, 64'hF0F0_F0F0_F0F0_F0F0, 2'd0);

    // Grant 2 (ptr 1 -> 3), then reset: the pending write is dropped.
    req_addr[2] = 6'd7;
    req_data[2] = 64'h7777;
    step("g2", 1'b1, 4'b0100, 4'b0100, 1'b1, 6'd7, 64'h7777, 2'd2);
    step("rstm", 1'b0, 4'b0100, 4'b0000, 1'b0, 6'd0, 64'd0, 2'd0);

    // After reset ptr is 0: with 2 and 3 valid, 2 is granted again, then 3.
    req_addr[3] = 6'd9;
    req_data[3] = 64'h9999;
    step("post2", 1'b1, 4'b1100, 4'b0100, 1'b1, 6'd7, 64'h7777, 2'd2);
    step("post3", 1'b1, 4'b1000, 4'b1000, 1'b1, 6'd9, 64'h9999, 2'd3);
    step("end",   1'b1, 4'b0000, 4'b0000, 1'b0, 6'd0, 64'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
